// File: rtl/bist_pkg.sv
// Shared types and constants for the built-in self-test sequencer and its pattern generators.
package bist_pkg;

    localparam int unsigned BIST_PAT_W   = 8;
    localparam int unsigned BIST_FLUSH_W = 4;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (feedback from bits 7,5,4,3)
    localparam logic [7:0] BIST_TAPS         = 8'hB8;
    localparam logic [7:0] BIST_DEFAULT_SEED = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } bist_state_t;

endpackage

// File: rtl/bist_controller_if.sv
// Control/status and pattern bus between the test controller, the BIST sequencer and the CUT/analyzer.
interface bist_controller_if #(
    parameter int unsigned PAT_W = 8
);
    logic             start;
    logic             abort;
    logic [7:0]       golden_sig;
    logic [7:0]       sig_in;
    logic             test_mode;
    logic [PAT_W-1:0] pattern;
    logic             pat_valid;
    logic             sa_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       result_sig;

    modport master (
        output start, abort, golden_sig, sig_in,
        input  test_mode, pattern, pat_valid, sa_rst, busy, done, pass, result_sig
    );

    modport slave (
        input  start, abort, golden_sig, sig_in,
        output test_mode, pattern, pat_valid, sa_rst, busy, done, pass, result_sig
    );
endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR pattern source with synchronous load and step enable; zero seeds are forced to 1.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int unsigned   W          = BIST_PAT_W,
    parameter logic [W-1:0]  TAPS       = W'(BIST_TAPS),
    parameter logic [W-1:0]  RESET_SEED = W'(BIST_DEFAULT_SEED)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] seed,
    output logic [W-1:0] pattern
);

    // An all-zero state would lock the register up, so it is never loaded
    localparam logic [W-1:0] RESET_SAFE = (RESET_SEED == '0) ? W'(1) : RESET_SEED;

    logic [W-1:0] seed_safe;

    assign seed_safe = (seed == '0) ? W'(1) : seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= RESET_SAFE;
        end else if (load) begin
            pattern <= seed_safe;
        end else if (advance) begin
            pattern <= {pattern[W-2:0], ^(pattern & TAPS)};
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: clears the analyzer, streams LFSR patterns into the CUT, drains, and grades the signature.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned      PAT_W        = BIST_PAT_W,
    parameter int unsigned      NUM_PATTERNS = 255,
    parameter int unsigned      FLUSH_CYC    = 2,
    parameter logic [PAT_W-1:0] SEED         = PAT_W'(BIST_DEFAULT_SEED)
) (
    input  logic               clk,
    input  logic               reset,
    bist_controller_if.slave   bus
);

    localparam int unsigned               CNT_W      = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0]          LAST_PAT   = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [BIST_FLUSH_W-1:0]   LAST_FLUSH = BIST_FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [PAT_W-1:0]          SEED_EFF   = (SEED == '0) ? PAT_W'(1) : SEED;

    bist_state_t               state, state_next;
    logic [CNT_W-1:0]          pat_cnt, pat_cnt_next;
    logic [BIST_FLUSH_W-1:0]   flush_cnt, flush_cnt_next;
    logic [7:0]                golden, golden_next;
    logic [7:0]                result_sig_q, result_sig_next;
    logic                      pass_q, pass_next;
    logic                      lfsr_load, lfsr_advance;
    logic                      accept, running;

    logic test_mode_q, test_mode_next;
    logic pat_valid_q, pat_valid_next;
    logic sa_rst_q, sa_rst_next;
    logic busy_q, busy_next;
    logic done_q, done_next;

    logic [PAT_W-1:0] pattern_q;

    bist_lfsr #(
        .W          (PAT_W),
        .TAPS       (PAT_W'(BIST_TAPS)),
        .RESET_SEED (SEED_EFF)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (SEED_EFF),
        .pattern (pattern_q)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counters, result capture and next values of the registered outputs
    always_comb begin
        state_next      = state;
        pat_cnt_next    = pat_cnt;
        flush_cnt_next  = flush_cnt;
        golden_next     = golden;
        result_sig_next = result_sig_q;
        pass_next       = pass_q;
        lfsr_load       = 1'b0;
        lfsr_advance    = 1'b0;
        accept          = 1'b0;
        running         = state inside {S_CLEAR, S_RUN, S_FLUSH, S_COMPARE};

        if (running && bus.abort) begin
            state_next = S_IDLE;
            pass_next  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        accept = 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_next   = S_RUN;
                    pat_cnt_next = '0;
                end
                S_RUN: begin
                    // The last vector is held through the drain, so no step on the way out
                    if (pat_cnt == LAST_PAT) begin
                        state_next     = S_FLUSH;
                        flush_cnt_next = '0;
                    end else begin
                        pat_cnt_next = pat_cnt + CNT_W'(1);
                        lfsr_advance = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state_next = S_COMPARE;
                    end else begin
                        flush_cnt_next = flush_cnt + BIST_FLUSH_W'(1);
                    end
                end
                S_COMPARE: begin
                    result_sig_next = bus.sig_in;
                    pass_next       = (bus.sig_in == golden);
                    state_next      = S_DONE;
                end
                S_DONE: begin
                    if (bus.start) begin
                        accept = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        if (accept) begin
            state_next      = S_CLEAR;
            golden_next     = bus.golden_sig;
            lfsr_load       = 1'b1;
            pass_next       = 1'b0;
            result_sig_next = '0;
            pat_cnt_next    = '0;
            flush_cnt_next  = '0;
        end

        test_mode_next = state_next inside {S_CLEAR, S_RUN, S_FLUSH, S_COMPARE};
        busy_next      = state_next inside {S_CLEAR, S_RUN, S_FLUSH, S_COMPARE};
        pat_valid_next = (state_next == S_RUN);
        sa_rst_next    = (state_next == S_CLEAR);
        done_next      = (state_next == S_DONE);
    end

    // Counters, latched golden value, result and output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_cnt      <= '0;
            flush_cnt    <= '0;
            golden       <= '0;
            result_sig_q <= '0;
            pass_q       <= 1'b0;
            test_mode_q  <= 1'b0;
            pat_valid_q  <= 1'b0;
            sa_rst_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pat_cnt      <= pat_cnt_next;
            flush_cnt    <= flush_cnt_next;
            golden       <= golden_next;
            result_sig_q <= result_sig_next;
            pass_q       <= pass_next;
            test_mode_q  <= test_mode_next;
            pat_valid_q  <= pat_valid_next;
            sa_rst_q     <= sa_rst_next;
            busy_q       <= busy_next;
            done_q       <= done_next;
        end
    end

    assign bus.test_mode  = test_mode_q;
    assign bus.pattern    = pattern_q;
    assign bus.pat_valid  = pat_valid_q;
    assign bus.sa_rst     = sa_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.result_sig = result_sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller with a behavioural CUT + signature analyzer around it.
module tb_bist_controller;

    logic       clk;
    logic       reset;
    logic [7:0] key;

    bist_controller_if #(.PAT_W(8)) bus ();

    bist_controller #(
        .PAT_W        (8),
        .NUM_PATTERNS (255),
        .FLUSH_CYC    (2),
        .SEED         (8'h01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] key;
        int         flip;
        int         abort_at;
        bit         noise;
        bit         exp_pass;
        bit         exp_done;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] ref_pats[$];
    logic [7:0] last_pats[$];

    // Stand-in CUT function: a keyed mix of the operand
    function automatic logic [7:0] cut_f(input logic [7:0] p, input logic [7:0] k);
        return 8'((int'(p ^ k) + 'h35) & 'hFF);
    endfunction

    // CUT (1 register stage) and rotating signature analyzer, as seen by the sequencer
    logic [7:0] cut_q;
    logic       cut_v;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cut_q      <= 8'h00;
            cut_v      <= 1'b0;
            bus.sig_in <= 8'h00;
        end else begin
            cut_q <= cut_f(bus.test_mode ? bus.pattern : 8'h00, key);
            cut_v <= bus.pat_valid;
            if (bus.sa_rst) bus.sig_in <= 8'h00;
            else if (cut_v) bus.sig_in <= {bus.sig_in[6:0], bus.sig_in[7]} ^ cut_q;
        end
    end

    // Reference: pattern list from the polynomial rule, signature folded over it
    task automatic build_model(input logic [7:0] k, output logic [7:0] sig);
        int p, s, b;
        p = 1;
        s = 0;
        ref_pats.delete();
        for (int i = 0; i < 255; i++) begin
            ref_pats.push_back(8'(p));
            s = (((s << 1) | (s >> 7)) & 255) ^ int'(cut_f(8'(p), k));
            b = ((p >> 7) ^ (p >> 5) ^ (p >> 4) ^ (p >> 3)) & 1;
            p = ((p << 1) | b) & 255;
        end
        sig = 8'(s);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One full run from IDLE; optional abort on a given RUN cycle and start noise during RUN
    task automatic do_run(input vec_t v);
        logic [7:0] msig, gold;
        int  n, nvalid, sa_cnt, done_at, bad;
        bit  aborted, seen_done;
        build_model(v.key, msig);
        gold = msig ^ ((v.flip >= 0) ? 8'(1 << v.flip) : 8'h00);
        key = v.key;
        bus.golden_sig = gold;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.golden_sig = ~gold;
        last_pats.delete();
        n = 1; nvalid = 0; sa_cnt = 0; done_at = -1; aborted = 0;
        while (n <= 300 && done_at < 0 && !aborted) begin
            if (bus.pat_valid) begin
                last_pats.push_back(bus.pattern);
                nvalid++;
            end
            if (bus.sa_rst) sa_cnt++;
            if (bus.done) begin
                done_at = n;
            end else begin
                bus.abort = (v.abort_at >= 0) && bus.pat_valid && (nvalid - 1 == v.abort_at);
                aborted   = bus.abort;
                bus.start = v.noise && bus.pat_valid && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("run_done_seen", 32'(done_at >= 0), 32'(v.exp_done));
        if (aborted) begin
            chk("abort_busy", 32'(bus.busy), 32'(0));
            chk("abort_test_mode", 32'(bus.test_mode), 32'(0));
            chk("abort_pat_valid", 32'(bus.pat_valid), 32'(0));
            chk("abort_pass", 32'(bus.pass), 32'(0));
            chk("abort_result_hold", 32'(bus.result_sig), 32'(0));
            seen_done = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus.done) seen_done = 1;
            end
            chk("abort_no_done", 32'(seen_done), 32'(0));
        end else begin
            chk("latency", 32'(done_at), 32'(260));
            chk("pat_valid_cycles", 32'(nvalid), 32'(255));
            chk("sa_rst_pulses", 32'(sa_cnt), 32'(1));
            bad = 0;
            for (int i = 0; i < last_pats.size() && i < ref_pats.size(); i++)
                if (last_pats[i] !== ref_pats[i]) bad++;
            chk("pattern_stream", 32'(bad), 32'(0));
            chk("result_sig", 32'(bus.result_sig), 32'(msig));
            chk("pass", 32'(bus.pass), 32'(v.exp_pass));
            chk("done_busy_low", 32'(bus.busy), 32'(0));
            @(negedge clk);
            chk("done_one_cycle", 32'(bus.done), 32'(0));
            chk("result_hold", 32'(bus.result_sig), 32'(msig));
            chk("pass_hold", 32'(bus.pass), 32'(v.exp_pass));
        end
    endtask

    initial begin
        logic [7:0] exp5[5];
        logic [7:0] msig, r1;
        bit         seen[256];
        int         n, dup, zero, flip, ab;
        bit         found;

        exp5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        vecs[0] = '{8'h00, -1,  -1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h00,  3,  -1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, -1, 100, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, -1,  -1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'hC3,  7,  -1, 1'b1, 1'b0, 1'b1};
        for (int i = 5; i < 9; i++) begin
            flip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 254)) : -1;
            vecs[i] = '{8'($urandom), flip, ab, 1'b1, (flip < 0 && ab < 0), (ab < 0)};
        end

        reset = 1'b1;
        key = 8'h00;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.golden_sig = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'(0));
        chk("reset_test_mode", 32'(bus.test_mode), 32'(0));
        chk("reset_pat_valid", 32'(bus.pat_valid), 32'(0));
        chk("reset_sa_rst", 32'(bus.sa_rst), 32'(0));
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_pass", 32'(bus.pass), 32'(0));
        chk("reset_result", 32'(bus.result_sig), 32'(0));
        chk("reset_pattern", 32'(bus.pattern), 32'(8'h01));
        reset = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_no_effect", 32'(bus.busy), 32'(0));

        for (int i = 0; i < 9; i++) begin
            do_run(vecs[i]);
            if (i == 0) begin
                for (int j = 0; j < 5 && j < last_pats.size(); j++)
                    chk("first_patterns", 32'(last_pats[j]), 32'(exp5[j]));
                dup = 0; zero = 0;
                for (int j = 0; j < 256; j++) seen[j] = 0;
                foreach (last_pats[j]) begin
                    if (last_pats[j] == 8'h00) zero++;
                    if (seen[last_pats[j]]) dup++;
                    seen[last_pats[j]] = 1;
                end
                chk("period_count", 32'(last_pats.size()), 32'(255));
                chk("period_distinct", 32'(dup), 32'(0));
                chk("period_nonzero", 32'(zero), 32'(0));
            end
        end

        // start and abort together in IDLE: start wins; then abort during CLEAR
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_beats_abort", 32'(bus.sa_rst & bus.busy), 32'(1));
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_in_clear", 32'(bus.busy | bus.test_mode), 32'(0));
        @(negedge clk);

        // back-to-back: start held through DONE
        build_model(8'h77, msig);
        key = 8'h77;
        bus.golden_sig = msig;
        bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 300);
        chk("b2b_first_latency", 32'(n), 32'(260));
        chk("b2b_first_pass", 32'(bus.pass), 32'(1));
        r1 = bus.result_sig;
        @(negedge clk);
        chk("b2b_clear_sa_rst", 32'(bus.sa_rst), 32'(1));
        chk("b2b_clear_busy", 32'(bus.busy), 32'(1));
        bus.start = 1'b0;
        bus.golden_sig = msig ^ 8'h01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 300);
        chk("b2b_second_latency", 32'(n), 32'(259));
        chk("b2b_second_result", 32'(bus.result_sig), 32'(r1));
        chk("b2b_second_pass", 32'(bus.pass), 32'(1));
        @(negedge clk);

        // asynchronous reset in the middle of FLUSH
        key = 8'h3C;
        bus.golden_sig = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (n > 2 && bus.busy && !bus.pat_valid && !bus.sa_rst) found = 1;
        end
        chk("reach_flush", 32'(found), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 32'(bus.busy), 32'(0));
        chk("async_test_mode", 32'(bus.test_mode), 32'(0));
        chk("async_pattern", 32'(bus.pattern), 32'(8'h01));
        chk("async_done", 32'(bus.done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        found = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) found = 1;
        end
        chk("async_no_done", 32'(found), 32'(0));
        do_run(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Built-in self-test sequencer for the 8-bit datapath and its signature analyzer.
- On `start`, it clears the analyzer and drives a maximal-length LFSR pattern stream into the circuit-under-test (CUT) for NUM_PATTERNS cycles.
- It then waits for the CUT pipeline to drain and samples the analyzer's signature.
- It compares the signature against a golden value and reports pass/fail.
- It sits between the top-level test/control logic and the CUT operand mux plus the signature analyzer.

Parameters:
- PAT_W, 8: pattern width. The LFSR polynomial below is defined for 8 only.
- NUM_PATTERNS, 255: patterns applied per run. Range 1..255.
- FLUSH_CYC, 2: idle cycles after the last pattern before the signature is sampled. Covers CUT latency plus analyzer capture. Range 1..15.
- SEED, 8'h01: LFSR load value. A value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin a run. Sampled in IDLE and DONE only.
- abort  in  1  abandon the current run
- golden_sig  in  8  expected signature. Latched on an accepted start.
- sig_in  in  8  signature from the analyzer
- test_mode  out  1  selects the pattern onto the CUT operand mux
- pattern  out  PAT_W  current test pattern
- pat_valid  out  1  pattern is a counted test vector this cycle
- sa_rst  out  1  registered clear pulse to the signature analyzer
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the result is valid
- pass  out  1  result_sig == latched golden
- result_sig  out  8  captured signature

Behaviour:
- Reset values:
  - state = IDLE.
  - test_mode, pat_valid, sa_rst, busy, done, pass = 0.
  - pattern = SEED, result_sig = 0, counters = 0.
- All outputs are driven from flops; no combinational paths from inputs to outputs.
- LFSR (Fibonacci, x^8+x^6+x^5+x^4+1): next = {p[6:0], p[7]^p[5]^p[4]^p[3]}. It advances only in RUN, one step per cycle.
- Pattern counter width: clog2(NUM_PATTERNS+1). Flush counter width: 4 bits.
- FSM states: IDLE, CLEAR, RUN, FLUSH, COMPARE, DONE.
  - IDLE:
    - On start=1: latch golden_sig, load pattern=SEED, clear pass and result_sig, go to CLEAR.
  - CLEAR (exactly 1 cycle):
    - sa_rst=1, test_mode=1, busy=1. Then go to RUN.
  - RUN (exactly NUM_PATTERNS cycles):
    - pat_valid=1, test_mode=1. pattern holds vector k during the k-th RUN cycle.
    - When count reaches NUM_PATTERNS-1, go to FLUSH.
  - FLUSH (exactly FLUSH_CYC cycles):
    - pat_valid=0, test_mode=1. pattern holds the last vector.
  - COMPARE (1 cycle):
    - result_sig <= sig_in; pass <= (sig_in == golden).
    - test_mode drops to 0 entering DONE.
  - DONE:
    - done=1 for exactly 1 cycle, busy=0.
    - result_sig and pass hold until the next accepted start.
    - Then go to IDLE, except that start=1 in DONE goes straight to CLEAR (back-to-back runs).
- start while busy is ignored. It is not queued.
- abort in CLEAR/RUN/FLUSH/COMPARE:
  - Go to IDLE next cycle with test_mode=0, pat_valid=0, busy=0, done=0.
  - pass=0 and result_sig unchanged.
  - abort has priority over all other transitions.
- abort in IDLE or DONE: no effect.
- Simultaneous start and abort in IDLE: start wins; abort is only honoured while busy.
- Asynchronous reset mid-run: everything returns to reset values immediately. No done pulse.
- Latency from start to done: 1 + NUM_PATTERNS + FLUSH_CYC + 1 + 1 cycles (260 with defaults). busy covers every cycle from CLEAR through COMPARE.

Decomposition:
- Shared package bist_pkg holds:
  - state enum bist_state_t;
  - LFSR tap constant BIST_TAPS = 8'hB8 (bits 7,5,4,3);
  - BIST_DEFAULT_SEED.
- One natural sub-module: bist_lfsr (load, advance, seed, pattern out), reusable by other TPGs.
- The FSM and counters stay in bist_controller.

Test Plan:
1. Reset, then start with defaults:
   - pattern in RUN cycles 0..4 = 01, 02, 04, 08, 11.
   - pat_valid high for exactly 255 cycles.
   - done pulses 260 cycles after start.
2. Period check: record all 255 RUN patterns → all distinct and nonzero; pattern 0 = 01.
3. golden_sig = model signature of a known-good CUT → pass=1, result_sig equals the model. Flip one golden bit → pass=0, same result_sig.
4. abort on RUN cycle 100 → IDLE next cycle, busy=0, no done, pass=0. A new start then produces a correct full run.
5. start held high through DONE → back-to-back run: CLEAR begins the cycle after done; sa_rst pulses again; second result equals the first. start pulses during RUN are ignored.
6. Async reset asserted mid-FLUSH → outputs at reset values within the same cycle; no done; next start runs normally.
